// File: rtl/hazard_pkg.sv
// Shared types and encodings for the RV32I pipeline hazard/sequencing controller.
package hazard_pkg;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
    localparam logic [1:0] PCSRC_SEQ      = 2'b00;

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m,
                                           input logic [4:0] rd_w,
                                           input logic       wr_m,
                                           input logic       wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: forwarding, load-use stall, redirect flush, boot hold and debug drain/halt.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       PCSrcE,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TMAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] BOOT_LD  = TW'(BOOT_CYCLES);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYCLES);

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            lw, redir;
    logic            stall_inc, flush_inc;

    assign lw    = (ResultSrcE == RESULTSRC_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    assign redir = (PCSrcE != PCSRC_SEQ);

    assign ForwardAE = (state_q == BOOT) ? FWD_RF : fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = (state_q == BOOT) ? FWD_RF : fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        halted_o  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            BOOT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (tmr_q <= TW'(1))
                    state_d = RUN;
                else
                    tmr_d = tmr_q - TW'(1);
            end
            RUN: begin
                // A redirect means D holds wrong-path code, so it overrides a load-use stall.
                StallF    = lw && !redir;
                StallD    = lw && !redir;
                FlushD    = redir;
                FlushE    = lw || redir;
                stall_inc = lw && !redir;
                flush_inc = redir;
                if (halt_i) begin
                    state_d = DRAIN;
                    tmr_d   = DRAIN_LD;
                end
            end
            DRAIN: begin
                if (redir) begin
                    // Let the PC take the target so resume refetches the right path.
                    FlushD    = 1'b1;
                    FlushE    = 1'b1;
                    flush_inc = 1'b1;
                    tmr_d     = DRAIN_LD;
                end else if (lw) begin
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    FlushE    = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                    if (tmr_q <= TW'(1))
                        state_d = HALTED;
                    else
                        tmr_d = tmr_q - TW'(1);
                end
            end
            HALTED: begin
                halted_o = 1'b1;
                StallF   = 1'b1;
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                if (resume_i)
                    state_d = RUN;
            end
            default: begin
                state_d = BOOT;
                tmr_d   = BOOT_LD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            tmr_q   <= BOOT_LD;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (stall_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (flush_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (flush_cnt)
    );

endmodule
